pc_cmd_seq_gen: RTL



---
 rtl/pc_cmd_seq_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pc_cmd_seq_gen.sv
// Command-driven tagged sequence generator between a FWFT command FIFO and an output FIFO.
// Optional statistics outputs (stat_words, stat_stalls) are enabled by defining PC_SEQ_STATS_EN.
module pc_cmd_seq_gen #(
  parameter int CMD_W  = 32,
  parameter int CNT_W  = 24,
  parameter int TAG_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              bus_clk,
  input  logic              reset_n,
  input  logic              cmd_empty,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_rd_en,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_data,
  output logic              eof,
  output logic              busy,
  output logic [TAG_W-1:0]  tag
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [31:0]       stat_words,
  output logic [31:0]       stat_stalls
`endif
);

  // state | meaning
  // IDLE  | no run active; only command decode
  // RUN   | emitting sequence words while remaining != 0
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [1:0] OP_STOP       = 2'b00;
  localparam logic [1:0] OP_START_DOWN = 2'b01;
  localparam logic [1:0] OP_START_UP   = 2'b10;
  localparam logic [1:0] OP_LOAD_TAG   = 2'b11;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               dir_up_q, dir_up_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               eof_q, eof_d;
  logic               rd_en_q;

  logic               accept;
  logic               emit;
  logic               start_acc;
  logic [1:0]         op;
  logic [CNT_W-1:0]   arg;
  logic               unused_cmd_bits;

  assign op     = cmd_data[CMD_W-1:CMD_W-2];
  assign arg    = cmd_data[CNT_W-1:0];
  // Argument bits above CNT_W are deliberately ignored.
  assign unused_cmd_bits = ^cmd_data;

  // The registered pop blocks the next accept, so a stale FWFT head is never decoded twice.
  assign accept    = !cmd_empty && !rd_en_q;
  assign emit      = (state_q == RUN) && !out_full && !accept;
  assign start_acc = accept && ((op == OP_START_DOWN) || (op == OP_START_UP));

  assign cmd_rd_en = rd_en_q;
  assign out_wr_en = emit;
  assign busy      = (state_q == RUN);
  assign tag       = tag_q;
  assign eof       = eof_q;

  always_comb begin
    out_data = '0;
    out_data[TAG_W+CNT_W-1:0] = {tag_q, cnt_q};
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dir_up_q <= 1'b0;
      tag_q    <= '0;
      eof_q    <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dir_up_q <= dir_up_d;
      tag_q    <= tag_d;
      eof_q    <= eof_d;
      rd_en_q  <= accept;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dir_up_d = dir_up_q;
    tag_d    = tag_q;
    eof_d    = eof_q;
    if (accept) begin
      case (op)
        OP_START_DOWN: begin
          cnt_d    = arg;
          rem_d    = arg;
          dir_up_d = 1'b0;
          eof_d    = 1'b0;
          state_d  = (arg != '0) ? RUN : IDLE;
        end
        OP_START_UP: begin
          cnt_d    = '0;
          rem_d    = arg;
          dir_up_d = 1'b1;
          eof_d    = 1'b0;
          state_d  = (arg != '0) ? RUN : IDLE;
        end
        OP_LOAD_TAG: begin
          tag_d = arg[TAG_W-1:0];
        end
        default: begin
          state_d = IDLE;
          rem_d   = '0;
          if (arg == '0) eof_d = 1'b1;
        end
      endcase
    end else if (emit) begin
      rem_d = rem_q - 1'b1;
      cnt_d = dir_up_q ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
      if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = IDLE;
    end
  end

`ifdef PC_SEQ_STATS_EN
  logic [31:0] words_q, words_d;
  logic [31:0] stalls_q, stalls_d;

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      words_q  <= words_d;
      stalls_q <= stalls_d;
    end
  end

  always_comb begin
    words_d  = words_q;
    stalls_d = stalls_q;
    if (start_acc) begin
      words_d  = '0;
      stalls_d = '0;
    end else begin
      if (emit && (words_q != '1)) words_d = words_q + 1'b1;
      if ((state_q == RUN) && out_full && (stalls_q != '1)) stalls_d = stalls_q + 1'b1;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
